// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator.
// - Preset constants for the 640x480@60 timing set.
// - sync_bundle_t: raw per-pixel flags carried through the output delay line.
// - calc_total(): line/frame total from its four segments.
package video_timing_pkg;

  localparam int unsigned Vga640HActive = 640;
  localparam int unsigned Vga640HFp     = 16;
  localparam int unsigned Vga640HSync   = 96;
  localparam int unsigned Vga640HBp     = 48;
  localparam int unsigned Vga640VActive = 480;
  localparam int unsigned Vga640VFp     = 10;
  localparam int unsigned Vga640VSync   = 2;
  localparam int unsigned Vga640VBp     = 33;

  // Sync flags are active-high here; output polarity is applied at the top.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic frame_start;
  } sync_bundle_t;

  function automatic int unsigned calc_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync_w,
                                             input int unsigned bp);
    return active + fp + sync_w + bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Depth-stage shift register with clock enable and synchronous reset.
// Ports:
//   clk_i  - clock
//   rst_ni - synchronous active-low reset, loads ResetVal into every stage
//   en_i   - advance strobe; stages hold when low
//   d_i    - input word
//   q_o    - output of the last stage (d_i directly when Depth == 0)
module sync_delay_line #(
  parameter int unsigned      Depth    = 2,
  parameter int unsigned      Width    = 4,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, en_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [Width-1:0] stage_q [Depth];
    logic [Width-1:0] stage_d [Depth];

    always_comb begin
      for (int i = 0; i < Depth; i++) stage_d[i] = stage_q[i];
      if (en_i) begin
        stage_d[0] = d_i;
        for (int i = 1; i < Depth; i++) stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < Depth; i++) stage_q[i] <= ResetVal;
      end else begin
        for (int i = 0; i < Depth; i++) stage_q[i] <= stage_d[i];
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable, X/Y counters, and DE/Hsync/Vsync
// aligned to a downstream fetch of PIPE pixels latency.
// Ports:
//   Clock, Reset_n (synchronous, active-low), Enable (run request)
//   Pix_ce       - one-Clock pixel strobe
//   X, Y         - undelayed raster counters
//   Fetch_active - undelayed active-video flag
//   Line_start   - undelayed, on the strobe of X==0 while running
//   DE, Hsync, Vsync, Frame_start - delayed by PIPE strobes
//   Running      - high while in the run state
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = Vga640HActive,
  parameter int unsigned H_FP     = Vga640HFp,
  parameter int unsigned H_SYNC   = Vga640HSync,
  parameter int unsigned H_BP     = Vga640HBp,
  parameter int unsigned V_ACTIVE = Vga640VActive,
  parameter int unsigned V_FP     = Vga640VFp,
  parameter int unsigned V_SYNC   = Vga640VSync,
  parameter int unsigned V_BP     = Vga640VBp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CE_DIV   = 2,
  parameter int unsigned PIPE     = 2,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 10
) (
  input  logic           Clock,
  input  logic           Reset_n,
  input  logic           Enable,
  output logic           Pix_ce,
  output logic [X_W-1:0] X,
  output logic [Y_W-1:0] Y,
  output logic           Fetch_active,
  output logic           Line_start,
  output logic           DE,
  output logic           Hsync,
  output logic           Vsync,
  output logic           Frame_start,
  output logic           Running
);

  localparam int unsigned HTotal  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd   = HsStart + H_SYNC;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd   = VsStart + V_SYNC;
  localparam int unsigned CntW    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CE_DIV - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ce_ok_q, ce_ok_d;
  logic [0:0]      state_q, state_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic            pix_ce, live, last_x, last_y;
  sync_bundle_t    raw, dly;

  // ce_ok_q holds the prescaler at 0 for the first cycle out of reset, so the
  // first strobe lands CE_DIV-1 Clocks later and Pix_ce is low right after reset.
  assign pix_ce = ce_ok_q && (cnt_q == CntLast);
  // The strobe that leaves IDLE already counts as pixel (0,0).
  assign live   = (state_q == StRun) || (pix_ce && Enable);
  assign last_x = (x_q == X_W'(HTotal - 1));
  assign last_y = (y_q == Y_W'(VTotal - 1));

  always_comb begin
    ce_ok_d = 1'b1;
    if (!ce_ok_q || cnt_q == CntLast) cnt_d = '0;
    else                              cnt_d = cnt_q + CntW'(1);

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (pix_ce && live) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
      // Stop only on the last pixel of a frame so frames are never truncated.
      if (state_q == StIdle)                  state_d = StRun;
      else if (last_x && last_y && !Enable)   state_d = StIdle;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      cnt_q   <= '0;
      ce_ok_q <= 1'b0;
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ce_ok_q <= ce_ok_d;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    raw = '0;
    if (live) begin
      raw.active      = (x_q < X_W'(H_ACTIVE)) && (y_q < Y_W'(V_ACTIVE));
      raw.hsync       = (x_q >= X_W'(HsStart)) && (x_q < X_W'(HsEnd));
      raw.vsync       = (y_q >= Y_W'(VsStart)) && (y_q < Y_W'(VsEnd));
      raw.frame_start = (x_q == '0) && (y_q == '0);
    end
  end

  // Keeps shifting in IDLE so it drains to inactive values.
  sync_delay_line #(
    .Depth   (PIPE),
    .Width   ($bits(sync_bundle_t)),
    .ResetVal('0)
  ) u_delay (
    .clk_i (Clock),
    .rst_ni(Reset_n),
    .en_i  (pix_ce),
    .d_i   (raw),
    .q_o   (dly)
  );

  assign Pix_ce       = pix_ce;
  assign X            = x_q;
  assign Y            = y_q;
  assign Fetch_active = raw.active;
  assign Line_start   = pix_ce && live && (x_q == '0);
  assign DE           = dly.active;
  assign Hsync        = dly.hsync ? HS_POL : !HS_POL;
  assign Vsync        = dly.vsync ? VS_POL : !VS_POL;
  assign Frame_start  = dly.frame_start;
  assign Running      = (state_q == StRun);

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with four parameter sets:
//   def  - 640x480 defaults (line-level checks)
//   tiny - H 4/1/2/1, V 3/1/1/1, CE_DIV=1, PIPE=0 (full-frame trace)
//   mid  - H 8/2/3/2, V 5/1/2/1, CE_DIV=2, PIPE=3 (pipe, frame, stop/restart, reset)
//   pol  - tiny timing, PIPE=1, active-high syncs
module tb_video_timing_gen;

  logic clk;
  int   n_cmp, n_bad;

  logic rst_def, en_def, rst_tiny, en_tiny, rst_mid, en_mid, rst_pol, en_pol;

  logic       pix_def, fetch_def, ls_def, de_def, hs_def, vs_def, fs_def, run_def;
  logic [9:0] x_def, y_def;
  logic       pix_tiny, fetch_tiny, ls_tiny, de_tiny, hs_tiny, vs_tiny, fs_tiny, run_tiny;
  logic [3:0] x_tiny, y_tiny;
  logic       pix_mid, fetch_mid, ls_mid, de_mid, hs_mid, vs_mid, fs_mid, run_mid;
  logic [3:0] x_mid, y_mid;
  logic       pix_pol, fetch_pol, ls_pol, de_pol, hs_pol, vs_pol, fs_pol, run_pol;
  logic [3:0] x_pol, y_pol;

  video_timing_gen u_def (
    .Clock(clk), .Reset_n(rst_def), .Enable(en_def), .Pix_ce(pix_def), .X(x_def), .Y(y_def),
    .Fetch_active(fetch_def), .Line_start(ls_def), .DE(de_def), .Hsync(hs_def),
    .Vsync(vs_def), .Frame_start(fs_def), .Running(run_def)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CE_DIV(1), .PIPE(0), .X_W(4), .Y_W(4)
  ) u_tiny (
    .Clock(clk), .Reset_n(rst_tiny), .Enable(en_tiny), .Pix_ce(pix_tiny), .X(x_tiny),
    .Y(y_tiny), .Fetch_active(fetch_tiny), .Line_start(ls_tiny), .DE(de_tiny),
    .Hsync(hs_tiny), .Vsync(vs_tiny), .Frame_start(fs_tiny), .Running(run_tiny)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(5), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CE_DIV(2), .PIPE(3), .X_W(4), .Y_W(4)
  ) u_mid (
    .Clock(clk), .Reset_n(rst_mid), .Enable(en_mid), .Pix_ce(pix_mid), .X(x_mid),
    .Y(y_mid), .Fetch_active(fetch_mid), .Line_start(ls_mid), .DE(de_mid),
    .Hsync(hs_mid), .Vsync(vs_mid), .Frame_start(fs_mid), .Running(run_mid)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CE_DIV(1), .PIPE(1), .X_W(4), .Y_W(4)
  ) u_pol (
    .Clock(clk), .Reset_n(rst_pol), .Enable(en_pol), .Pix_ce(pix_pol), .X(x_pol),
    .Y(y_pol), .Fetch_active(fetch_pol), .Line_start(ls_pol), .DE(de_pol),
    .Hsync(hs_pol), .Vsync(vs_pol), .Frame_start(fs_pol), .Running(run_pol)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_mid_xy(input int xw, input int yw, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (int'(x_mid) == xw && int'(y_mid) == yw) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  // Hand-derived per-position patterns for the tiny timing (bit index = X or Y).
  logic [7:0] tiny_de_x, tiny_hs_x;
  logic [5:0] tiny_de_y, tiny_vs_y;
  logic [14:0] tiny_exp;
  int xi, yi, clk_cnt, str_cnt, de_cnt, hs_first, hs_last, vs_bad;
  int s, f_first, d_first, f_cnt, d_cnt, vs_low, hs_low, k, hs_hi, vs_hi;
  bit prev, found, seen_last, last_run;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tiny_de_x = 8'b0000_1111;
    tiny_hs_x = 8'b1001_1111;
    tiny_de_y = 6'b00_0111;
    tiny_vs_y = 6'b10_1111;
    {rst_def, rst_tiny, rst_mid, rst_pol} = 4'b0000;
    {en_def, en_tiny, en_mid, en_pol} = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset values: {pix, X, Y, DE, Hs, Vs, Fs, Ls, Fetch, Running}.
    check_eq("rst_def", 32'({pix_def, x_def, y_def, de_def, hs_def, vs_def, fs_def, ls_def,
                              fetch_def, run_def}), 32'h30);
    check_eq("rst_tiny", 32'({pix_tiny, x_tiny, y_tiny, de_tiny, hs_tiny, vs_tiny, fs_tiny,
                               ls_tiny, fetch_tiny, run_tiny}), 32'h30);
    check_eq("rst_mid", 32'({pix_mid, x_mid, y_mid, de_mid, hs_mid, vs_mid, fs_mid, ls_mid,
                              fetch_mid, run_mid}), 32'h30);
    check_eq("rst_pol", 32'({pix_pol, x_pol, y_pol, de_pol, hs_pol, vs_pol, fs_pol, ls_pol,
                              fetch_pol, run_pol}), 32'h00);

    // ---- defaults: strobe cadence, line length, hsync placement ----
    rst_def = 1'b1;
    en_def  = 1'b1;
    @(negedge clk);
    check_eq("def_first_ce_lo", 32'(pix_def), 32'd0);
    @(negedge clk);
    check_eq("def_first_ce_hi", 32'({pix_def, ls_def, fetch_def, x_def}), 32'h1C00);
    clk_cnt = 0; str_cnt = 0; de_cnt = 0; hs_first = -1; hs_last = -1; vs_bad = 0;
    for (int i = 0; i < 4000; i++) begin
      if (pix_def) begin
        str_cnt++;
        if (de_def) de_cnt++;
      end
      if (!hs_def) begin
        if (hs_first < 0) hs_first = int'(x_def);
        hs_last = int'(x_def);
      end
      if (!vs_def) vs_bad++;
      @(negedge clk);
      clk_cnt++;
      if (ls_def) break;
    end
    check_eq("def_line_clocks", 32'(clk_cnt), 32'd1600);
    check_eq("def_line_strobes", 32'(str_cnt), 32'd800);
    check_eq("def_de_strobes", 32'(de_cnt), 32'd640);
    check_eq("def_hs_first_x", 32'(hs_first - 2), 32'd656);
    check_eq("def_hs_last_x", 32'(hs_last - 2), 32'd751);
    check_eq("def_vs_line0", 32'(vs_bad), 32'd0);

    // ---- tiny: cycle-exact trace over one frame plus the next frame start ----
    rst_tiny = 1'b1;
    en_tiny  = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 48; i++) begin
      xi = i % 8;
      yi = (i / 8) % 6;
      tiny_exp = {1'b1, 4'(xi), 4'(yi), tiny_de_x[xi] & tiny_de_y[yi], tiny_hs_x[xi],
                  tiny_vs_y[yi], (xi == 0), (xi == 0 && yi == 0), (i > 0)};
      check_eq($sformatf("tiny_trace_%0d", i),
               32'({pix_tiny, x_tiny, y_tiny, de_tiny, hs_tiny, vs_tiny, ls_tiny, fs_tiny,
                    run_tiny}), 32'(tiny_exp));
      @(negedge clk);
    end

    // ---- mid: pipe alignment ----
    rst_mid = 1'b1;
    en_mid  = 1'b1;
    @(negedge clk);
    check_eq("mid_first_ce_lo", 32'(pix_mid), 32'd0);
    @(negedge clk);
    s = 0; f_first = -1; d_first = -1; f_cnt = 0; d_cnt = 0;
    for (int i = 0; i < 40 && s < 15; i++) begin
      if (pix_mid) begin
        if (fetch_mid) begin
          f_cnt++;
          if (f_first < 0) f_first = s;
        end
        if (de_mid) begin
          d_cnt++;
          if (d_first < 0) d_first = s;
        end
        s++;
      end
      @(negedge clk);
    end
    check_eq("mid_fetch_first", 32'(f_first), 32'd0);
    check_eq("mid_de_first", 32'(d_first), 32'd3);
    check_eq("mid_fetch_len", 32'(f_cnt), 32'd8);
    check_eq("mid_de_len", 32'(d_cnt), 32'd8);

    // ---- mid: frame period and sync widths ----
    found = 1'b0;
    prev  = fs_mid;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fs_mid && !prev) begin
        found = 1'b1;
        break;
      end
      prev = fs_mid;
    end
    check_eq("mid_fs_seen", 32'(found), 32'd1);
    clk_cnt = 0; vs_low = 0; hs_low = 0; prev = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (pix_mid) begin
        if (!vs_mid) vs_low++;
        if (!hs_mid) hs_low++;
      end
      @(negedge clk);
      clk_cnt++;
      if (fs_mid && !prev) break;
      prev = fs_mid;
    end
    check_eq("mid_frame_clocks", 32'(clk_cnt), 32'd270);
    check_eq("mid_vs_strobes", 32'(vs_low), 32'd30);
    check_eq("mid_hs_strobes", 32'(hs_low), 32'd27);

    // ---- mid: enable dropped mid-frame, frame completes ----
    wait_mid_xy(4, 2, "mid_wait_drop");
    en_mid = 1'b0;
    seen_last = 1'b0;
    last_run  = 1'b0;
    for (int i = 0; i < 400 && run_mid; i++) begin
      if (pix_mid && x_mid == 4'd14 && y_mid == 4'd8) begin
        seen_last = 1'b1;
        last_run  = run_mid;
      end
      @(negedge clk);
    end
    check_eq("mid_stop_at_last", 32'({seen_last, last_run}), 32'h3);
    check_eq("mid_idle_state", 32'({x_mid, y_mid, run_mid, de_mid, fetch_mid}), 32'h0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (fs_mid || de_mid || run_mid || ls_mid) k++;
      @(negedge clk);
    end
    check_eq("mid_idle_quiet", 32'(k), 32'd0);

    // Enable high only between strobes must not start the raster.
    if (pix_mid) @(negedge clk);
    en_mid = 1'b1;
    @(negedge clk);
    en_mid = 1'b0;
    @(negedge clk);
    check_eq("mid_en_glitch", 32'({run_mid, x_mid}), 32'h0);

    // ---- mid: restart at (0,0) with a delayed frame start ----
    if (pix_mid) @(negedge clk);
    en_mid = 1'b1;
    @(negedge clk);
    check_eq("mid_restart", 32'({pix_mid, ls_mid, fetch_mid, x_mid, y_mid}), 32'h700);
    k = 0;
    for (int i = 0; i < 20 && !fs_mid; i++) begin
      if (pix_mid) k++;
      @(negedge clk);
    end
    check_eq("mid_restart_fs", 32'({fs_mid, 8'(k)}), 32'h103);

    // ---- mid: one-Clock reset pulse while both syncs are asserted ----
    wait_mid_xy(14, 7, "mid_wait_rst");
    check_eq("mid_pre_rst_sync", 32'({hs_mid, vs_mid}), 32'h0);
    rst_mid = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_pulse", 32'({pix_mid, x_mid, y_mid, de_mid, hs_mid, vs_mid, fs_mid,
                                    ls_mid, fetch_mid, run_mid}), 32'h30);
    rst_mid = 1'b1;

    // ---- pol: active-high syncs, widths unchanged ----
    rst_pol = 1'b1;
    en_pol  = 1'b1;
    repeat (10) @(negedge clk);
    hs_hi = 0;
    vs_hi = 0;
    for (int i = 0; i < 48; i++) begin
      if (hs_pol) hs_hi++;
      if (vs_pol) vs_hi++;
      @(negedge clk);
    end
    check_eq("pol_hs_high", 32'(hs_hi), 32'd12);
    check_eq("pol_vs_high", 32'(vs_hi), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised successor to the fixed 640x480 pixel cursor. Generates raster counters, DE, Hsync and Vsync for the ADV7513 from one system clock, using a pixel clock-enable instead of a divided clock. Adds:
- programmable timings and sync polarity;
- frame and line start pulses;
- clean start/stop at frame boundaries;
- a configurable output pipeline that aligns DE and sync with a downstream pixel fetch of known latency.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, Hsync active level (0 = active-low)
- VS_POL, 0, Vsync active level
- CE_DIV, 2, Clock cycles per pixel (≥1)
- PIPE, 2, pixel-enable delay applied to DE/Hsync/Vsync/Frame_start (≥0)
- X_W, 10, width of X (≥ clog2(H_TOTAL))
- Y_W, 10, width of Y (≥ clog2(V_TOTAL))

Ports:
- Clock  in  1  system clock (50 MHz)
- Reset_n  in  1  synchronous, active-low reset
- Enable  in  1  run request; sampled as described below
- Pix_ce  out  1  one-Clock pixel strobe
- X  out  X_W  horizontal counter, undelayed
- Y  out  Y_W  vertical counter, undelayed
- Fetch_active  out  1  undelayed active-video flag, for address generation
- Line_start  out  1  undelayed; high on the Pix_ce where X==0 in RUN
- DE  out  1  delayed active video
- Hsync  out  1  delayed, polarity HS_POL
- Vsync  out  1  delayed, polarity VS_POL
- Frame_start  out  1  delayed one-pixel pulse at X==0, Y==0
- Running  out  1  high in RUN

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise.
- Line order: active, front porch, sync, back porch. Frame order is the same.
- Prescaler counts 0..CE_DIV-1. Pix_ce is high when the count equals CE_DIV-1. With CE_DIV=1, Pix_ce is constantly high after reset.
- States: IDLE, RUN.
- IDLE:
  - X=Y=0; Fetch_active=0; Line_start=0; Running=0.
  - Goes to RUN on a Pix_ce with Enable=1. That same Pix_ce is pixel (0,0).
- RUN, on each Pix_ce:
  - X increments and wraps to 0 at H_TOTAL-1.
  - On X wrap, Y increments and wraps to 0 at V_TOTAL-1.
  - Fetch_active = (X<H_ACTIVE && Y<V_ACTIVE).
  - Raw hsync is asserted for H_ACTIVE+H_FP ≤ X < H_ACTIVE+H_FP+H_SYNC.
  - Raw vsync uses the same rule on Y and is line-granular.
- Stop: when Enable=0 on the last pixel of a frame (X=H_TOTAL-1, Y=V_TOTAL-1, Pix_ce), go to IDLE. Deasserting Enable mid-frame never truncates a frame.
- Delay line:
  - Raw {active, hsync, vsync, frame_start} shift through PIPE stages, advancing only on Pix_ce.
  - The line keeps shifting in IDLE and flushes with inactive values.
  - With PIPE=0, outputs are combinational from the counters.
- Sync outputs drive the inactive level (~HS_POL, ~VS_POL) whenever their raw value is 0.

## Timing
- Reset (Reset_n=0 at a Clock edge), required values:
  - state IDLE; prescaler 0; X=Y=0
  - all delay stages inactive
  - DE=0, Frame_start=0, Line_start=0, Fetch_active=0, Pix_ce=0, Running=0
  - Hsync=~HS_POL, Vsync=~VS_POL
- Reset is honoured mid-line and mid-frame. It takes priority over Enable and Pix_ce.
- First Pix_ce occurs CE_DIV-1 Clocks after the first cycle with Reset_n=1.
- Output DE for pixel (x,y) appears exactly PIPE Pix_ce strobes after Fetch_active for that pixel.
- Frame period: H_TOTAL*V_TOTAL*CE_DIV Clocks. Line period: H_TOTAL*CE_DIV Clocks.
- Enable changes between Pix_ce strobes have no effect until the next strobe.

## Structure
- Package video_timing_pkg holds:
  - preset constants for the 640x480@60 timing set (defaults above);
  - a typedef for the raw sync bundle {active, hsync, vsync, frame_start};
  - a function for the total-count calculation.
- Sub-module sync_delay_line: PIPE-deep shift register with clock-enable and synchronous reset to a parameter value. It is instantiated once on the bundle.

## Test plan
- Default parameters, Enable=1 from reset:
  - Pix_ce every 2 Clocks;
  - 800 strobes per line, 525 lines per frame;
  - Frame_start period 840000 Clocks;
  - Hsync low for X=656..751, Vsync low for Y=490..491.
- Tiny timing (H 4/1/2/1, V 3/1/1/1), CE_DIV=1, PIPE=0: Hsync and DE patterns match hand-computed traces cycle-for-cycle, with H_TOTAL=8 and V_TOTAL=6.
- PIPE=3: DE rises exactly 3 Pix_ce strobes after Fetch_active rises. Both stay high for H_ACTIVE strobes.
- Enable dropped at X=100, Y=200: frame completes, then Running=0 and X=Y=0. DE falls after PIPE strobes. Re-enable restarts at (0,0) with a Frame_start pulse.
- Reset_n pulsed low for one Clock at X=300, Y=50: all outputs take their reset values at that edge, with Hsync/Vsync at the inactive level.
- HS_POL=1, VS_POL=1: idle level 0, sync pulses high, widths unchanged.
